// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multi-port register file
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int NWRITE    = 2;
  // Write port that wins on a same-register conflict (writes and bypass)
  localparam int PRIO_PORT = 1;

  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits, issue set beats write-back clear
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int AW       = addr_width(DEF_NREGS),
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_reg,
  output logic [NREGS-1:0]     busy
);

  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      logic set_r;
      logic clr_r;
      set_r = issue_valid && (issue_reg == AW'(r));
      clr_r = 1'b0;
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) clr_r = 1'b1;
      end
      // A newly issued producer supersedes the one completing this cycle
      if (set_r)      busy_nxt[r] = 1'b1;
      else if (clr_r) busy_nxt[r] = 1'b0;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NWRITE-1:0]       writeEnable,
  input  logic [NWRITE*AW-1:0]    writeRegister,
  input  logic [NWRITE*XLEN-1:0]  writeData,
  input  logic [NREAD*AW-1:0]     readRegister,
  output logic [NREAD*XLEN-1:0]   readData,
  input  logic                    issueValid,
  input  logic [AW-1:0]           issueReg,
  output logic [NREGS-1:0]        busy
);

  localparam int LO_PORT = 1 - PRIO_PORT;

  logic [XLEN-1:0] regs [NREGS];

  function automatic logic write_ok(input logic en, input logic [AW-1:0] addr);
    return en && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // Priority port is written last so it overrides on an address conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      if (write_ok(writeEnable[LO_PORT], writeRegister[LO_PORT*AW +: AW]))
        regs[writeRegister[LO_PORT*AW +: AW]] <= writeData[LO_PORT*XLEN +: XLEN];
      if (write_ok(writeEnable[PRIO_PORT], writeRegister[PRIO_PORT*AW +: AW]))
        regs[writeRegister[PRIO_PORT*AW +: AW]] <= writeData[PRIO_PORT*XLEN +: XLEN];
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = readRegister[k*AW +: AW];

    always_comb begin
      rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
      if (writeEnable[LO_PORT] && (writeRegister[LO_PORT*AW +: AW] == ra))
        rd = writeData[LO_PORT*XLEN +: XLEN];
      if (writeEnable[PRIO_PORT] && (writeRegister[PRIO_PORT*AW +: AW] == ra))
        rd = writeData[PRIO_PORT*XLEN +: XLEN];
`endif
      if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
    end

    assign readData[k*XLEN +: XLEN] = rd;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (writeEnable),
    .wr_addr     (writeRegister),
    .issue_valid (issueValid),
    .issue_reg   (issueReg),
    .busy        (busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            writeEnable;
  logic [2*AW-1:0]       writeRegister;
  logic [2*XLEN-1:0]     writeData;
  logic [NREAD*AW-1:0]   readRegister;
  logic [NREAD*XLEN-1:0] readData;
  logic                  issueValid;
  logic [AW-1:0]         issueReg;
  logic [NREGS-1:0]      busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          port;
    logic [4:0]  addr;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [NREGS];

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .ZERO_REG (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .writeEnable   (writeEnable),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .readRegister  (readRegister),
    .readData      (readData),
    .issueValid    (issueValid),
    .issueReg      (issueReg),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input int port, input logic [4:0] addr, input string tag);
    exp_t e;
    e.port = port;
    e.addr = addr;
    e.data = model[addr];
    e.tag  = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      readRegister[e.port*AW +: AW] = e.addr;
      #1;
      chk(e.tag, readData[e.port*XLEN +: XLEN], e.data);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic iv, input logic [4:0] ir);
    writeEnable   = en;
    writeRegister = {a1, a0};
    writeData     = {d1, d0};
    issueValid    = iv;
    issueReg      = ir;
  endtask

  task automatic idle();
    writeEnable = 2'b00;
    issueValid  = 1'b0;
  endtask

  task automatic commit(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    if (en[0] && a0 != 0) model[a0] = d0;
    if (en[1] && a1 != 0) model[a1] = d1;
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) model[r] = '0;
    rst_n        = 1'b0;
    readRegister = '0;
    drive(2'b11, 5'd5, 32'hCAFE_0001, 5'd6, 32'hCAFE_0002, 1'b1, 5'd5);
    repeat (3) step();
    idle();
    #2 rst_n = 1'b1;
    step();
    for (int p = 0; p < NREAD; p++) begin
      push_read(p, 5'd5, "reset_r5");
      push_read(p, 5'd6, "reset_r6");
    end
    drain();
    chk("reset_busy", busy, 32'h0);

    // Single write r5
    drive(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0);
    readRegister[0 +: AW] = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", readData[0 +: XLEN], 32'hDEAD_BEEF);
`else
    chk("no_bypass_same_cycle", readData[0 +: XLEN], 32'h0);
`endif
    step();
    commit(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
    idle();
    push_read(0, 5'd5, "single_write_p0");
    push_read(1, 5'd5, "single_write_p1");
    drain();

    // Dual write same register: port 1 wins
    drive(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0);
    readRegister[AW +: AW] = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_prio", readData[XLEN +: XLEN], 32'h22);
`else
    chk("no_bypass_prio", readData[XLEN +: XLEN], 32'h0);
`endif
    step();
    commit(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
    idle();
    push_read(0, 5'd7, "dual_same_r7");
    drain();
    chk("dual_same_val", model[7], 32'h22);

    // Dual write distinct registers
    drive(2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 1'b0, 5'd0);
    step();
    commit(2'b11, 5'd3, 32'h33, 5'd4, 32'h44);
    idle();
    push_read(0, 5'd3, "dual_diff_r3");
    push_read(1, 5'd4, "dual_diff_r4");
    drain();

    // Zero register: writes dropped, never busy, never bypassed
    drive(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    readRegister[0 +: AW] = 5'd0;
    #1;
    chk("zero_no_bypass", readData[0 +: XLEN], 32'h0);
    step();
    commit(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
    idle();
    push_read(0, 5'd0, "zero_read_p0");
    push_read(1, 5'd0, "zero_read_p1");
    drain();
    chk("zero_busy", busy, 32'h0);

    // Scoreboard set / set-beats-clear / clear
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
    #1;
    chk("busy_before_edge", busy, 32'h0);
    step();
    idle();
    chk("busy_set_r9", busy, 32'h0000_0200);
    drive(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9);
    step();
    commit(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    idle();
    chk("busy_set_wins", busy, 32'h0000_0200);
    drive(2'b10, 5'd0, 32'h0, 5'd9, 32'h999, 1'b0, 5'd0);
    step();
    commit(2'b10, 5'd0, 32'h0, 5'd9, 32'h999);
    idle();
    chk("busy_clear_r9", busy, 32'h0);
    push_read(1, 5'd9, "sb_r9_data");
    drain();

    // Issue two registers, clear one via port 0 while setting another
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd31);
    step();
    drive(2'b01, 5'd31, 32'h1F, 5'd0, 32'h0, 1'b1, 5'd1);
    step();
    commit(2'b01, 5'd31, 32'h1F, 5'd0, 32'h0);
    idle();
    chk("busy_swap", busy, 32'h0000_0002);

    // Sweep: value i into register i, two registers per cycle on alternating ports
    for (int i = 1; i < NREGS; i += 2) begin
      logic [4:0] a0;
      logic [4:0] a1;
      a0 = 5'(i);
      a1 = 5'(i + 1);
      if (i + 1 < NREGS) begin
        drive(2'b11, a0, 32'(i), a1, 32'(i + 1), 1'b0, 5'd0);
        step();
        commit(2'b11, a0, 32'(i), a1, 32'(i + 1));
      end else begin
        drive(2'b10, 5'd0, 32'h0, a0, 32'(i), 1'b0, 5'd0);
        step();
        commit(2'b10, 5'd0, 32'h0, a0, 32'(i));
      end
    end
    idle();
    for (int i = 1; i < NREGS; i++) begin
      chk("sweep_model", model[i], 32'(i));
      for (int p = 0; p < NREAD; p++) push_read(p, 5'(i), "sweep");
    end
    drain();
    chk("sweep_busy", busy, 32'h0);

    // Async reset mid-write clears everything
    drive(2'b01, 5'd12, 32'hABCD_0000, 5'd0, 32'h0, 1'b1, 5'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_read", readData[0 +: XLEN], 32'h0);
    step();
    idle();
    #2 rst_n = 1'b1;
    for (int r = 0; r < NREGS; r++) model[r] = '0;
    step();
    push_read(0, 5'd12, "rst_mid_r12");
    push_read(1, 5'd20, "rst_mid_r20");
    drain();
    chk("rst_mid_busy", busy, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
